// File: rtl/run_ctrl_if.sv
// rtl/run_ctrl_if.sv - Host/core handshake bundle between the host pins, the core and run_ctrl
interface run_ctrl_if #(
    parameter int unsigned IW = 9,
    parameter int unsigned CW = 16
);
    logic          Req;
    logic [IW-1:0] Instr;
    logic          Done;
    logic          Busy;
    logic          PCInit;
    logic          CoreRun;
    logic [CW-1:0] CycleCount;
    logic          Timeout;

    modport master (
        output Req,
        output Instr,
        input  Done,
        input  Busy,
        input  PCInit,
        input  CoreRun,
        input  CycleCount,
        input  Timeout
    );

    modport slave (
        input  Req,
        input  Instr,
        output Done,
        output Busy,
        output PCInit,
        output CoreRun,
        output CycleCount,
        output Timeout
    );
endinterface

// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - Start/done responder: PC init, core run enable, halt/budget stop, cycle count
module run_ctrl #(
    parameter int unsigned    IW         = 9,
    parameter logic [IW-1:0]  HALT       = 9'b011111111,
    parameter int unsigned    CW         = 16,
    parameter logic [CW-1:0]  MAX_CYCLES = 16'd4096
) (
    input  logic      Clk_i,
    input  logic      Reset_i,
    run_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [CW-1:0] LAST_CYCLE = MAX_CYCLES - CW'(1);

    state_e        state_q, state_d;
    logic [CW-1:0] cycles_q, cycles_d;
    logic          timeout_q, timeout_d;

    logic is_halt;
    logic at_budget;

    assign is_halt   = (bus.Instr == HALT);
    assign at_budget = (cycles_q == LAST_CYCLE);

    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            state_q   <= IDLE;
            cycles_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cycles_q  <= cycles_d;
            timeout_q <= timeout_d;
        end
    end

    // HALT outranks the budget, and both outrank a host abort in the same cycle.
    always_comb begin
        state_d   = state_q;
        cycles_d  = cycles_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (bus.Req) begin
                    state_d = INIT;
                end
            end
            INIT: begin
                state_d   = RUN;
                cycles_d  = '0;
                timeout_d = 1'b0;
            end
            RUN: begin
                cycles_d = cycles_q + CW'(1);
                if (is_halt) begin
                    state_d = DONE;
                end else if (at_budget) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end else if (!bus.Req) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (!bus.Req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // CoreRun is the only output that looks at Instr, so the halt word is never executed.
    always_comb begin
        bus.Done       = (state_q == DONE);
        bus.Busy       = (state_q == INIT) || (state_q == RUN);
        bus.PCInit     = (state_q == INIT);
        bus.CoreRun    = (state_q == RUN) && !is_halt;
        bus.CycleCount = cycles_q;
        bus.Timeout    = timeout_q;
    end

endmodule

// File: tb/tb_run_ctrl.sv
// tb/tb_run_ctrl.sv - Scenario bench for run_ctrl with an expected-result queue per run
module tb_run_ctrl;

    localparam logic [8:0]  HALT = 9'b011111111;
    localparam logic [15:0] MAXC = 16'd8;

    typedef struct {
        int count;
        bit timeout;
        bit done;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    run_ctrl_if #(.IW(9), .CW(16)) bus ();

    run_ctrl #(
        .IW(9), .HALT(HALT), .CW(16), .MAX_CYCLES(MAXC)
    ) dut (
        .Clk_i(clk),
        .Reset_i(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] rand_op();
        logic [8:0] v;
        v = 9'($urandom_range(0, 510));
        if (v == HALT) v = 9'h1FF;
        return v;
    endfunction

    // Drives one run from IDLE and records what the DUT did; comparisons are made by the caller.
    task automatic drive_run(input int halt_at, input int abort_at,
                             output int run_cyc, output int core_cyc, output int pcinit_cyc,
                             output int pcinit_at, output int done_at, output bit overlap,
                             output bit hung);
        bit started;
        started = 0;
        run_cyc = 0; core_cyc = 0; pcinit_cyc = 0; pcinit_at = -1; done_at = -1;
        overlap = 0; hung = 1;
        @(negedge clk);
        bus.Req   = 1'b1;
        bus.Instr = rand_op();
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (bus.PCInit) begin
                pcinit_cyc++;
                if (pcinit_at < 0) pcinit_at = cyc;
            end
            if (bus.Busy && !bus.PCInit) begin
                bus.Instr = (run_cyc == halt_at) ? HALT : rand_op();
                if (run_cyc == abort_at) bus.Req = 1'b0;
                run_cyc++;
            end else begin
                bus.Instr = rand_op();
            end
            #1;
            if (bus.CoreRun) core_cyc++;
            if (bus.Done && bus.Busy) overlap = 1;
            if (bus.Busy) started = 1;
            if (bus.Done) begin
                done_at = cyc;
                hung = 0;
                break;
            end
            if (started && !bus.Busy) begin
                hung = 0;
                break;
            end
        end
    endtask

    task automatic release_req();
        @(negedge clk);
        bus.Req = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.Req = 1'b0;
        bus.Instr = rand_op();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.Done, bus.Busy, bus.PCInit, bus.CoreRun, bus.Timeout, bus.CycleCount} !== 21'd0) begin
            errors++;
            $display("FAIL reset_state: got %b required 0",
                     {bus.Done, bus.Busy, bus.PCInit, bus.CoreRun, bus.Timeout, bus.CycleCount});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_halt();
        int rc, cc, pc, pa, da;
        bit ov, hg;
        exp_t e;
        sb.push_back('{count: 6, timeout: 1'b0, done: 1'b1});
        drive_run(5, -1, rc, cc, pc, pa, da, ov, hg);
        e = sb.pop_front();
        checks++;
        if (hg !== 1'b0) begin errors++; $display("FAIL basic_hang: run did not finish"); end
        checks++;
        if (pa !== 0 || pc !== 1) begin
            errors++; $display("FAIL basic_pcinit: at=%0d pulses=%0d required at=0 pulses=1", pa, pc);
        end
        checks++;
        if (cc !== 5) begin errors++; $display("FAIL basic_corerun: got %0d required 5", cc); end
        checks++;
        if (da !== pa + rc + 1) begin
            errors++; $display("FAIL basic_done_latency: got %0d required %0d", da - pa, rc + 1);
        end
        checks++;
        if (bus.CycleCount !== 16'(e.count) || bus.Timeout !== e.timeout || bus.Done !== e.done) begin
            errors++;
            $display("FAIL basic_result: count=%0d to=%0b done=%0b required %0d %0b %0b",
                     bus.CycleCount, bus.Timeout, bus.Done, e.count, e.timeout, e.done);
        end
        checks++;
        if (ov !== 1'b0) begin errors++; $display("FAIL basic_overlap: Done with Busy"); end
    endtask

    task automatic test_four_phase();
        int bad;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            bus.Instr = rand_op();
            #1;
            if (!bus.Done || bus.PCInit || bus.Busy || bus.CoreRun) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL four_phase_hold: bad cycles %0d required 0", bad); end
        bus.Req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.Done !== 1'b0 || bus.CycleCount !== 16'd6) begin
            errors++;
            $display("FAIL four_phase_release: done=%0b count=%0d required 0 6", bus.Done, bus.CycleCount);
        end
        bus.Req = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.PCInit !== 1'b1) begin errors++; $display("FAIL four_phase_reinit: PCInit=%0b required 1", bus.PCInit); end
        @(negedge clk);
        bus.Instr = HALT;
        #1;
        checks++;
        if (bus.CycleCount !== 16'd0 || bus.CoreRun !== 1'b0 || bus.Busy !== 1'b1) begin
            errors++;
            $display("FAIL four_phase_clear: count=%0d corerun=%0b busy=%0b required 0 0 1",
                     bus.CycleCount, bus.CoreRun, bus.Busy);
        end
        @(negedge clk);
        checks++;
        if (bus.Done !== 1'b1 || bus.CycleCount !== 16'd1) begin
            errors++; $display("FAIL four_phase_rerun: done=%0b count=%0d required 1 1", bus.Done, bus.CycleCount);
        end
        release_req();
    endtask

    task automatic test_timeout(input int halt_at, input bit exp_to, input int exp_core);
        int rc, cc, pc, pa, da;
        bit ov, hg;
        exp_t e;
        sb.push_back('{count: 8, timeout: exp_to, done: 1'b1});
        drive_run(halt_at, -1, rc, cc, pc, pa, da, ov, hg);
        e = sb.pop_front();
        checks++;
        if (hg !== 1'b0 || cc !== exp_core) begin
            errors++; $display("FAIL timeout_corerun(halt_at=%0d): got %0d required %0d", halt_at, cc, exp_core);
        end
        checks++;
        if (bus.CycleCount !== 16'(e.count) || bus.Timeout !== e.timeout || bus.Done !== e.done) begin
            errors++;
            $display("FAIL timeout_result(halt_at=%0d): count=%0d to=%0b done=%0b required %0d %0b %0b",
                     halt_at, bus.CycleCount, bus.Timeout, bus.Done, e.count, e.timeout, e.done);
        end
        release_req();
    endtask

    task automatic test_abort();
        int rc, cc, pc, pa, da;
        bit ov, hg;
        exp_t e;
        sb.push_back('{count: 3, timeout: 1'b0, done: 1'b0});
        drive_run(-1, 2, rc, cc, pc, pa, da, ov, hg);
        e = sb.pop_front();
        checks++;
        if (hg !== 1'b0 || da !== -1 || cc !== 3) begin
            errors++; $display("FAIL abort_run: hung=%0b done_at=%0d corerun=%0d required 0 -1 3", hg, da, cc);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.CycleCount !== 16'(e.count) || bus.Timeout !== e.timeout || bus.Done !== e.done
            || bus.Busy !== 1'b0 || bus.CoreRun !== 1'b0) begin
            errors++;
            $display("FAIL abort_result: count=%0d to=%0b done=%0b busy=%0b required %0d %0b %0b 0",
                     bus.CycleCount, bus.Timeout, bus.Done, bus.Busy, e.count, e.timeout, e.done);
        end
    endtask

    task automatic test_immediate_halt();
        int rc, cc, pc, pa, da;
        bit ov, hg;
        exp_t e;
        sb.push_back('{count: 1, timeout: 1'b0, done: 1'b1});
        drive_run(0, -1, rc, cc, pc, pa, da, ov, hg);
        e = sb.pop_front();
        checks++;
        if (hg !== 1'b0 || cc !== 0 || da - pa !== 2) begin
            errors++; $display("FAIL immediate_halt: corerun=%0d latency=%0d required 0 2", cc, da - pa);
        end
        checks++;
        if (bus.CycleCount !== 16'(e.count) || bus.Timeout !== e.timeout) begin
            errors++; $display("FAIL immediate_result: count=%0d to=%0b required %0d %0b",
                               bus.CycleCount, bus.Timeout, e.count, e.timeout);
        end
        release_req();
    endtask

    task automatic test_back_to_back();
        int rc, cc, pc, pa, da;
        bit ov, hg;
        exp_t e;
        int halts[2];
        halts[0] = 2;
        halts[1] = 4;
        sb.push_back('{count: 3, timeout: 1'b0, done: 1'b1});
        sb.push_back('{count: 5, timeout: 1'b0, done: 1'b1});
        for (int r = 0; r < 2; r++) begin
            drive_run(halts[r], -1, rc, cc, pc, pa, da, ov, hg);
            e = sb.pop_front();
            checks++;
            if (hg !== 1'b0 || bus.CycleCount !== 16'(e.count) || bus.Done !== e.done || cc !== halts[r]) begin
                errors++;
                $display("FAIL back_to_back[%0d]: count=%0d done=%0b corerun=%0d required %0d %0b %0d",
                         r, bus.CycleCount, bus.Done, cc, e.count, e.done, halts[r]);
            end
            release_req();
        end
    endtask

    task automatic test_reset_midrun();
        int bad;
        bad = 0;
        @(negedge clk);
        bus.Req = 1'b1;
        bus.Instr = rand_op();
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.Done, bus.Busy, bus.PCInit, bus.CoreRun, bus.Timeout, bus.CycleCount} !== 21'd0) begin
            errors++;
            $display("FAIL reset_midrun: got %b required 0",
                     {bus.Done, bus.Busy, bus.PCInit, bus.CoreRun, bus.Timeout, bus.CycleCount});
        end
        bus.Req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (bus.Busy || bus.PCInit || bus.Done || bus.CoreRun) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL reset_quiet: active cycles %0d required 0", bad); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_halt();
        test_four_phase();
        test_timeout(-1, 1'b1, 8);
        test_abort();
        test_timeout(7, 1'b0, 7);
        test_immediate_halt();
        test_back_to_back();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Responder side of the host start/done handshake for the 9-bit-instruction core.
- Sits inside Top between the host/bench Req/Done pins and the core's PC, register file and data memory enables.
- On Req it re-initialises the PC, lets the core execute until the halt encoding is fetched (or a cycle budget expires), then raises Done and holds it until the host drops Req.
- Also reports the executed cycle count and a timeout flag.

Parameters:
- IW, 9, instruction width.
- HALT, 9'b011111111, instruction encoding that ends a run.
- CW, 16, width of the cycle counter.
- MAX_CYCLES, 16'd4096, RUN-cycle budget before forced stop; must be >= 1 and fit in CW bits.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Req  in  1  host start request; level, four-phase.
- Instr  in  IW  instruction currently fetched at the PC (combinational from instruction ROM).
- Done  out  1  run complete; the host's ack.
- Busy  out  1  high in INIT and RUN.
- PCInit  out  1  one-cycle pulse that loads the PC with 0.
- CoreRun  out  1  enable for PC advance, register file writes and data memory writes.
- CycleCount  out  CW  RUN cycles of the last or current run.
- Timeout  out  1  last run ended by budget, not by HALT.

Behaviour:
- Reset asserted (Reset=0), at any time including mid-run: state=IDLE, Done=0, Busy=0, PCInit=0, CoreRun=0, CycleCount=0, Timeout=0, immediately and asynchronously.
- States: IDLE, INIT, RUN, DONE; encoded as registered state.
- IDLE:
  - All outputs low except CycleCount and Timeout, which hold their last values.
  - Req=1 sampled -> INIT.
- INIT (exactly 1 cycle):
  - PCInit=1, Busy=1, CoreRun=0.
  - Clears CycleCount to 0 and Timeout to 0 at the exiting edge.
  - -> RUN, regardless of Req.
- RUN:
  - Busy=1.
  - CoreRun = (Instr != HALT), combinational, so the halt instruction is never executed.
  - CycleCount increments by 1 on every RUN cycle, including the halt cycle.
  - Instr==HALT -> DONE.
  - Otherwise, CycleCount==MAX_CYCLES-1 -> DONE with Timeout set to 1 at that edge.
  - If both happen in the same cycle, HALT wins and Timeout stays 0.
  - Req=0 in RUN (abort) -> IDLE next edge: CoreRun low, Done never asserted, CycleCount holds. Abort has lower priority than HALT/timeout in the same cycle.
- DONE:
  - Done=1, Busy=0, CoreRun=0; CycleCount and Timeout frozen.
  - Req=0 sampled -> IDLE, so Done falls one cycle after Req falls.
  - Done is never high while Busy is high.
- Latency: Req rise to first CoreRun cycle is 2 edges (IDLE->INIT, INIT->RUN). HALT fetched in cycle N gives Done high from cycle N+1.
- Back-to-back runs: Req must return low and Done must drop before a new INIT. Req held high across DONE never restarts a run.
- CycleCount never wraps; the timeout bound guarantees it.
- All outputs except CoreRun are registered or decoded from state only.

Test Plan:
- Basic halt:
  - Stimulus: Reset low 2 cycles then high; Instr = non-halt for 5 RUN cycles then HALT; Req=1.
  - Response: PCInit pulse 1 cycle after Req; CoreRun high 5 cycles and low on the HALT cycle; Done=1 next cycle; CycleCount=6; Timeout=0.
- Four-phase release:
  - Stimulus: from DONE, hold Req=1 for 10 cycles, then drop Req.
  - Response: Done stays 1, no second PCInit, Done=0 one cycle after Req=0. Then raise Req again and check a fresh INIT with CycleCount cleared to 0.
- Timeout:
  - Stimulus: MAX_CYCLES=8, Instr never HALT.
  - Response: CoreRun high 8 cycles, Done=1, Timeout=1, CycleCount=8.
  - Variant: HALT on the 8th RUN cycle gives Timeout=0.
- Abort:
  - Stimulus: drop Req after 3 RUN cycles.
  - Response: state IDLE next edge, Done never 1, CoreRun=0, CycleCount=3.
- Reset mid-run:
  - Stimulus: assert Reset=0 asynchronously (between edges) during RUN.
  - Response: CoreRun, Busy, Done, Timeout all 0 and CycleCount=0 before the next Clk edge; no activity until the next Req after release.
- Immediate halt:
  - Stimulus: Instr=HALT at the PC on the first RUN cycle.
  - Response: CoreRun never high, CycleCount=1, Done=1 two edges after INIT.
